regfile_scoreboard: RTL and testbench

Architectural register file with integrated write-tracking scoreboard; the receiving end of the writeback stage's register-write interface. Accepts the registered `result` / `Write` / `next_IR` triple from writeback, commits it to the 32 x 32-bit register array, and serves two combinational read ports to decode. A per-register pending counter, incremented at issue and decremented at writeback, drives a stall request for RAW hazards.

---
 rtl/regfile_scoreboard_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 151 +++++++++++++++
 tb/tb_regfile_scoreboard.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Register-file bus between writeback/decode and regfile_scoreboard.
// Groups the writeback commit, issue tracking and the two read ports.
interface regfile_scoreboard_if #(
    parameter int XLEN = 32
);
    logic            wb_write;
    logic [31:0]     wb_ir;
    logic [XLEN-1:0] wb_result;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_used;
    logic            rs2_used;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            stall;
    logic            err_ovf;

    modport master (
        output wb_write, wb_ir, wb_result,
        output iss_valid, iss_rd,
        output rs1_addr, rs2_addr, rs1_used, rs2_used,
        input  rs1_data, rs2_data, stall, err_ovf
    );

    modport slave (
        input  wb_write, wb_ir, wb_result,
        input  iss_valid, iss_rd,
        input  rs1_addr, rs2_addr, rs1_used, rs2_used,
        output rs1_data, rs2_data, stall, err_ovf
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 32 x XLEN register file with per-register pending-write counters for RAW stalls.
// Optional feature macro REGFILE_BYPASS_EN: writeback-to-read forwarding with hazard exemption.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 2
) (
    input logic                 i_clk1,
    input logic                 i_rst,
    regfile_scoreboard_if.slave bus
);
    localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PEND_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};

    logic [XLEN-1:0]  r_regs [32];
    logic [CNT_W-1:0] r_pend [32];
    logic             r_err_ovf;

    logic [4:0]       w_wb_rd;
    logic             w_wb_hit;
    logic             w_iss_hit;
    logic [31:0]      w_inc_vec;
    logic [31:0]      w_dec_vec;
    logic [CNT_W-1:0] w_pend_rs1;
    logic [CNT_W-1:0] w_pend_rs2;
    logic [CNT_W-1:0] w_pend_iss;
    logic             w_ovf_now;
    logic             w_hz1;
    logic             w_hz2;
    logic             w_full;
    logic [XLEN-1:0]  w_rs1_data;
    logic [XLEN-1:0]  w_rs2_data;
    logic             w_unused_ir;

    // Decode writeback/issue targets into one-hot increment/decrement vectors.
    always_comb begin
        w_wb_rd    = bus.wb_ir[11:7];
        w_wb_hit   = bus.wb_write && (w_wb_rd != 5'd0);
        w_iss_hit  = bus.iss_valid && (bus.iss_rd != 5'd0);
        w_inc_vec  = w_iss_hit ? (32'd1 << bus.iss_rd) : 32'd0;
        w_dec_vec  = w_wb_hit ? (32'd1 << w_wb_rd) : 32'd0;
        w_pend_rs1 = r_pend[bus.rs1_addr];
        w_pend_rs2 = r_pend[bus.rs2_addr];
        w_pend_iss = r_pend[bus.iss_rd];
        // A matching writeback in the same cycle nets out the increment, so no overflow then.
        w_ovf_now  = w_iss_hit && (w_pend_iss == PEND_MAX) && !w_dec_vec[bus.iss_rd];
    end

    assign w_unused_ir = ^{bus.wb_ir[31:12], bus.wb_ir[6:0]};

    // Read ports: x0 is hard zero, optional forwarding of the writeback value.
    always_comb begin
        w_rs1_data = {XLEN{1'b0}};
        w_rs2_data = {XLEN{1'b0}};
        if (bus.rs1_addr == 5'd0) begin
            w_rs1_data = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (w_wb_hit && (w_wb_rd == bus.rs1_addr)) begin
            w_rs1_data = bus.wb_result;
`endif
        end else begin
            w_rs1_data = r_regs[bus.rs1_addr];
        end
        if (bus.rs2_addr == 5'd0) begin
            w_rs2_data = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (w_wb_hit && (w_wb_rd == bus.rs2_addr)) begin
            w_rs2_data = bus.wb_result;
`endif
        end else begin
            w_rs2_data = r_regs[bus.rs2_addr];
        end
    end

    // Hazard detection: operand RAW on pending registers plus counter-full on issue.
    always_comb begin
        w_hz1 = bus.rs1_used && (bus.rs1_addr != 5'd0) && (w_pend_rs1 != PEND_ZERO);
        w_hz2 = bus.rs2_used && (bus.rs2_addr != 5'd0) && (w_pend_rs2 != PEND_ZERO);
`ifdef REGFILE_BYPASS_EN
        // Last outstanding write is being forwarded right now, so the operand is resolved.
        if (w_wb_hit && (w_wb_rd == bus.rs1_addr) && (w_pend_rs1 == PEND_ONE)) begin
            w_hz1 = 1'b0;
        end else begin
            w_hz1 = w_hz1;
        end
        if (w_wb_hit && (w_wb_rd == bus.rs2_addr) && (w_pend_rs2 == PEND_ONE)) begin
            w_hz2 = 1'b0;
        end else begin
            w_hz2 = w_hz2;
        end
`endif
        w_full = bus.iss_valid && (w_pend_iss == PEND_MAX);
    end

    assign bus.rs1_data = w_rs1_data;
    assign bus.rs2_data = w_rs2_data;
    assign bus.stall    = w_hz1 | w_hz2 | w_full;
    assign bus.err_ovf  = r_err_ovf;

    // Register array commit; entry 0 is only ever reset, never written.
    always_ff @(posedge i_clk1) begin
        if (!i_rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
        end else if (w_wb_hit) begin
            r_regs[w_wb_rd] <= bus.wb_result;
        end else begin
            r_regs[0] <= {XLEN{1'b0}};
        end
    end

    // Pending counters: saturate at both ends, issue+writeback to same register cancel.
    always_ff @(posedge i_clk1) begin
        if (!i_rst) begin
            for (int i = 0; i < 32; i++) begin
                r_pend[i] <= PEND_ZERO;
            end
        end else begin
            r_pend[0] <= PEND_ZERO;
            for (int i = 1; i < 32; i++) begin
                if (w_inc_vec[i] && w_dec_vec[i]) begin
                    r_pend[i] <= r_pend[i];
                end else if (w_inc_vec[i]) begin
                    if (r_pend[i] != PEND_MAX) begin
                        r_pend[i] <= r_pend[i] + PEND_ONE;
                    end else begin
                        r_pend[i] <= r_pend[i];
                    end
                end else if (w_dec_vec[i]) begin
                    if (r_pend[i] != PEND_ZERO) begin
                        r_pend[i] <= r_pend[i] - PEND_ONE;
                    end else begin
                        r_pend[i] <= r_pend[i];
                    end
                end else begin
                    r_pend[i] <= r_pend[i];
                end
            end
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge i_clk1) begin
        if (!i_rst) begin
            r_err_ovf <= 1'b0;
        end else begin
            r_err_ovf <= r_err_ovf | w_ovf_now;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; expectations follow the build's bypass setting.
module tb_regfile_scoreboard;
    logic clk1 = 1'b0;
    logic rst  = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    regfile_scoreboard_if #(.XLEN(32)) bus ();

    regfile_scoreboard #(.XLEN(32), .CNT_W(2)) dut (
        .i_clk1 (clk1),
        .i_rst  (rst),
        .bus    (bus)
    );

    always #5 clk1 = ~clk1;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic logic [31:0] mk_ir(input logic [4:0] rd);
        mk_ir = {20'h00000, rd, 7'b0110011};
    endfunction

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle();
        bus.wb_write  = 1'b0;
        bus.wb_ir     = 32'd0;
        bus.wb_result = 32'd0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = 5'd0;
        bus.rs1_addr  = 5'd0;
        bus.rs2_addr  = 5'd0;
        bus.rs1_used  = 1'b0;
        bus.rs2_used  = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] val);
        bus.wb_write  = 1'b1;
        bus.wb_ir     = mk_ir(rd);
        bus.wb_result = val;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd31;
        bus.rs1_used = 1'b1;
        bus.rs2_used = 1'b1;
        #1;
        checks++;
        if (bus.rs1_data !== 32'd0) begin
            $display("FAIL reset_rs1 got=%h exp=%h", bus.rs1_data, 32'd0); failures++;
        end
        checks++;
        if (bus.rs2_data !== 32'd0) begin
            $display("FAIL reset_rs2 got=%h exp=%h", bus.rs2_data, 32'd0); failures++;
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            $display("FAIL reset_stall got=%b exp=%b", bus.stall, 1'b0); failures++;
        end
        checks++;
        if (bus.err_ovf !== 1'b0) begin
            $display("FAIL reset_err got=%b exp=%b", bus.err_ovf, 1'b0); failures++;
        end
        idle();
    endtask

    task automatic test_write_read();
        logic [31:0] exp_byp;
        idle();
        wb(5'd5, 32'hDEADBEEF);
        bus.rs1_addr = 5'd5;
        #1;
        exp_byp = BYP ? 32'hDEADBEEF : 32'd0;
        checks++;
        if (bus.rs1_data !== exp_byp) begin
            $display("FAIL wb_cycle_read got=%h exp=%h", bus.rs1_data, exp_byp); failures++;
        end
        tick();
        idle();
        bus.rs1_addr = 5'd5;
        bus.rs1_used = 1'b1;
        #1;
        checks++;
        if (bus.rs1_data !== 32'hDEADBEEF) begin
            $display("FAIL write_read_x5 got=%h exp=%h", bus.rs1_data, 32'hDEADBEEF); failures++;
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            $display("FAIL stray_write_no_pend got=%b exp=%b", bus.stall, 1'b0); failures++;
        end
        wb(5'd0, 32'h00001234);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd0;
        tick();
        idle();
        bus.rs2_addr = 5'd0;
        bus.rs2_used = 1'b1;
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd0;
        #1;
        checks++;
        if (bus.rs2_data !== 32'd0) begin
            $display("FAIL x0_reads_zero got=%h exp=%h", bus.rs2_data, 32'd0); failures++;
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            $display("FAIL x0_no_stall got=%b exp=%b", bus.stall, 1'b0); failures++;
        end
        idle();
    endtask

    task automatic test_raw();
        logic       exp_stall;
        logic [31:0] exp_data;
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd7;
        tick();
        idle();
        bus.rs2_addr = 5'd7;
        bus.rs2_used = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            $display("FAIL raw_stall_after_issue got=%b exp=%b", bus.stall, 1'b1); failures++;
        end
        tick();
        checks++;
        if (bus.stall !== 1'b1) begin
            $display("FAIL raw_stall_holds got=%b exp=%b", bus.stall, 1'b1); failures++;
        end
        wb(5'd7, 32'hCAFEF00D);
        #1;
        exp_stall = BYP ? 1'b0 : 1'b1;
        exp_data  = BYP ? 32'hCAFEF00D : 32'd0;
        checks++;
        if (bus.stall !== exp_stall) begin
            $display("FAIL raw_wb_cycle_stall got=%b exp=%b", bus.stall, exp_stall); failures++;
        end
        checks++;
        if (bus.rs2_data !== exp_data) begin
            $display("FAIL raw_wb_cycle_data got=%h exp=%h", bus.rs2_data, exp_data); failures++;
        end
        tick();
        bus.wb_write = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            $display("FAIL raw_stall_cleared got=%b exp=%b", bus.stall, 1'b0); failures++;
        end
        checks++;
        if (bus.rs2_data !== 32'hCAFEF00D) begin
            $display("FAIL raw_data_after got=%h exp=%h", bus.rs2_data, 32'hCAFEF00D); failures++;
        end
        idle();
    endtask

    task automatic test_same_cycle();
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd3;
        tick();
        wb(5'd3, 32'h00000033);
        tick();
        idle();
        bus.rs1_addr = 5'd3;
        bus.rs1_used = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            $display("FAIL same_cycle_pend_kept got=%b exp=%b", bus.stall, 1'b1); failures++;
        end
        checks++;
        if (bus.rs1_data !== 32'h00000033) begin
            $display("FAIL same_cycle_data got=%h exp=%h", bus.rs1_data, 32'h00000033); failures++;
        end
        wb(5'd3, 32'h00000034);
        tick();
        bus.wb_write = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            $display("FAIL same_cycle_drain got=%b exp=%b", bus.stall, 1'b0); failures++;
        end
        idle();
    endtask

    task automatic test_unused_and_stray();
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd12;
        tick();
        idle();
        bus.rs1_addr = 5'd12;
        bus.rs1_used = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            $display("FAIL unused_operand got=%b exp=%b", bus.stall, 1'b0); failures++;
        end
        bus.rs1_used = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            $display("FAIL used_operand got=%b exp=%b", bus.stall, 1'b1); failures++;
        end
        wb(5'd12, 32'h0000000C);
        tick();
        wb(5'd20, 32'h00001400);
        tick();
        idle();
        bus.rs1_addr = 5'd20;
        bus.rs1_used = 1'b1;
        bus.rs2_addr = 5'd12;
        bus.rs2_used = 1'b1;
        #1;
        checks++;
        if (bus.rs1_data !== 32'h00001400) begin
            $display("FAIL stray_data got=%h exp=%h", bus.rs1_data, 32'h00001400); failures++;
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            $display("FAIL stray_pend_zero got=%b exp=%b", bus.stall, 1'b0); failures++;
        end
        checks++;
        if (bus.err_ovf !== 1'b0) begin
            $display("FAIL stray_err got=%b exp=%b", bus.err_ovf, 1'b0); failures++;
        end
        idle();
    endtask

    task automatic test_overflow();
        idle();
        for (int k = 0; k < 3; k++) begin
            bus.iss_valid = 1'b1;
            bus.iss_rd    = 5'd9;
            tick();
        end
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            $display("FAIL full_hazard got=%b exp=%b", bus.stall, 1'b1); failures++;
        end
        checks++;
        if (bus.err_ovf !== 1'b0) begin
            $display("FAIL err_before_ovf got=%b exp=%b", bus.err_ovf, 1'b0); failures++;
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.err_ovf !== 1'b1) begin
            $display("FAIL err_after_ovf got=%b exp=%b", bus.err_ovf, 1'b1); failures++;
        end
        bus.rs1_addr = 5'd9;
        bus.rs1_used = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            $display("FAIL ovf_pend_held got=%b exp=%b", bus.stall, 1'b1); failures++;
        end
        for (int k = 0; k < 2; k++) begin
            wb(5'd9, 32'h90 + k);
            tick();
        end
        bus.wb_write = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            $display("FAIL ovf_one_left got=%b exp=%b", bus.stall, 1'b1); failures++;
        end
        wb(5'd9, 32'h00000092);
        tick();
        bus.wb_write = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            $display("FAIL ovf_drained got=%b exp=%b", bus.stall, 1'b0); failures++;
        end
        checks++;
        if (bus.err_ovf !== 1'b1) begin
            $display("FAIL err_sticky got=%b exp=%b", bus.err_ovf, 1'b1); failures++;
        end
        idle();
    endtask

    task automatic test_reset_midflight();
        idle();
        for (int k = 0; k < 2; k++) begin
            bus.iss_valid = 1'b1;
            bus.iss_rd    = 5'd14;
            tick();
        end
        idle();
        wb(5'd14, 32'h00000055);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd15;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle();
        bus.rs1_addr = 5'd14;
        bus.rs1_used = 1'b1;
        bus.rs2_addr = 5'd5;
        bus.rs2_used = 1'b1;
        #1;
        checks++;
        if (bus.rs1_data !== 32'd0) begin
            $display("FAIL midrst_rs1 got=%h exp=%h", bus.rs1_data, 32'd0); failures++;
        end
        checks++;
        if (bus.rs2_data !== 32'd0) begin
            $display("FAIL midrst_rs2 got=%h exp=%h", bus.rs2_data, 32'd0); failures++;
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            $display("FAIL midrst_stall got=%b exp=%b", bus.stall, 1'b0); failures++;
        end
        checks++;
        if (bus.err_ovf !== 1'b0) begin
            $display("FAIL midrst_err got=%b exp=%b", bus.err_ovf, 1'b0); failures++;
        end
        bus.rs1_addr = 5'd15;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            $display("FAIL midrst_issue_dropped got=%b exp=%b", bus.stall, 1'b0); failures++;
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_raw();
        test_same_cycle();
        test_unused_and_stray();
        test_overflow();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
